// File: rtl/issue_scheduler.sv
// Dual-issue in-order dispatch: fetches an instruction pair, holds it per lane,
// and issues each lane against a register scoreboard (lane 1 always first).
module issue_scheduler #(
    parameter int                      INS_PART_WID = 4,
    parameter int                      NUM_REGS     = 16,
    parameter logic [INS_PART_WID-1:0] NOP_TYPE     = 4'hF,
    parameter int                      CNT_WID      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    inst_1_fetch,
    output logic                    inst_2_fetch,
    input  logic                    inst_1_valid,
    input  logic                    inst_2_valid,
    input  logic [INS_PART_WID-1:0] inst_1_type,
    input  logic [INS_PART_WID-1:0] inst_1_dest,
    input  logic [INS_PART_WID-1:0] inst_1_src0,
    input  logic [INS_PART_WID-1:0] inst_1_src1,
    input  logic [INS_PART_WID-1:0] inst_2_type,
    input  logic [INS_PART_WID-1:0] inst_2_dest,
    input  logic [INS_PART_WID-1:0] inst_2_src0,
    input  logic [INS_PART_WID-1:0] inst_2_src1,
    output logic                    iss_1_valid,
    output logic                    iss_2_valid,
    output logic [INS_PART_WID-1:0] iss_1_type,
    output logic [INS_PART_WID-1:0] iss_1_dest,
    output logic [INS_PART_WID-1:0] iss_1_src0,
    output logic [INS_PART_WID-1:0] iss_1_src1,
    output logic [INS_PART_WID-1:0] iss_2_type,
    output logic [INS_PART_WID-1:0] iss_2_dest,
    output logic [INS_PART_WID-1:0] iss_2_src0,
    output logic [INS_PART_WID-1:0] iss_2_src1,
    input  logic                    iss_1_ready,
    input  logic                    iss_2_ready,
    input  logic                    wb_1_valid,
    input  logic                    wb_2_valid,
    input  logic [INS_PART_WID-1:0] wb_1_dest,
    input  logic [INS_PART_WID-1:0] wb_2_dest,
    output logic [NUM_REGS-1:0]     sb_busy,
    output logic [CNT_WID-1:0]      issue_cnt,
    output logic [CNT_WID-1:0]      stall_cnt
);

    typedef enum logic [1:0] {S_FETCH, S_CAPTURE, S_ISSUE} state_t;

    state_t                  r_state;
    logic                    r_h1_valid, r_h2_valid;
    logic [INS_PART_WID-1:0] r_h1_type, r_h1_dest, r_h1_src0, r_h1_src1;
    logic [INS_PART_WID-1:0] r_h2_type, r_h2_dest, r_h2_src0, r_h2_src1;
    logic [NUM_REGS-1:0]     r_sb_busy;
    logic [CNT_WID-1:0]      r_issue_cnt, r_stall_cnt;

    logic                    w_nop_1, w_nop_2, w_haz_1, w_haz_2;
    logic                    w_xfer_1, w_xfer_2, w_intra_ok, w_hold_left;
    logic [NUM_REGS-1:0]     w_set, w_clr;

    always_comb begin
        w_nop_1    = (r_h1_type == NOP_TYPE);
        w_nop_2    = (r_h2_type == NOP_TYPE);
        w_haz_1    = !w_nop_1 && (r_sb_busy[r_h1_src0] || r_sb_busy[r_h1_src1] || r_sb_busy[r_h1_dest]);
        w_haz_2    = !w_nop_2 && (r_sb_busy[r_h2_src0] || r_sb_busy[r_h2_src1] || r_sb_busy[r_h2_dest]);
        iss_1_valid = r_h1_valid && !w_haz_1;
        w_xfer_1   = iss_1_valid && iss_1_ready;
        // Lane 1 issuing this cycle has not yet marked its dest busy, so compare directly.
        w_intra_ok = !(w_xfer_1 && !w_nop_1) ||
                     ((r_h1_dest != r_h2_src0) && (r_h1_dest != r_h2_src1) && (r_h1_dest != r_h2_dest));
        iss_2_valid = r_h2_valid && !w_haz_2 && (!r_h1_valid || w_xfer_1) && w_intra_ok;
        w_xfer_2   = iss_2_valid && iss_2_ready;
        w_hold_left = (r_h1_valid && !w_xfer_1) || (r_h2_valid && !w_xfer_2);
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
            localparam logic [INS_PART_WID-1:0] IDX = INS_PART_WID'(gi);
            assign w_set[gi] = (w_xfer_1 && !w_nop_1 && (r_h1_dest == IDX)) ||
                               (w_xfer_2 && !w_nop_2 && (r_h2_dest == IDX));
            assign w_clr[gi] = (wb_1_valid && (wb_1_dest == IDX)) ||
                               (wb_2_valid && (wb_2_dest == IDX));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_h1_valid <= 1'b0;
            r_h2_valid <= 1'b0;
            r_h1_type  <= '0; r_h1_dest <= '0; r_h1_src0 <= '0; r_h1_src1 <= '0;
            r_h2_type  <= '0; r_h2_dest <= '0; r_h2_src0 <= '0; r_h2_src1 <= '0;
        end else begin
            case (r_state)
                S_FETCH: r_state <= S_CAPTURE;
                S_CAPTURE: begin
                    r_h1_valid <= inst_1_valid;
                    r_h2_valid <= inst_2_valid;
                    r_h1_type  <= inst_1_type; r_h1_dest <= inst_1_dest;
                    r_h1_src0  <= inst_1_src0; r_h1_src1 <= inst_1_src1;
                    r_h2_type  <= inst_2_type; r_h2_dest <= inst_2_dest;
                    r_h2_src0  <= inst_2_src0; r_h2_src1 <= inst_2_src1;
                    r_state    <= (inst_1_valid || inst_2_valid) ? S_ISSUE : S_FETCH;
                end
                S_ISSUE: begin
                    if (w_xfer_1) r_h1_valid <= 1'b0;
                    if (w_xfer_2) r_h2_valid <= 1'b0;
                    if (!w_hold_left) r_state <= S_FETCH;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Set is ORed in after the clear so a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sb_busy   <= '0;
            r_issue_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_sb_busy   <= (r_sb_busy & ~w_clr) | w_set;
            r_issue_cnt <= r_issue_cnt + CNT_WID'(w_xfer_1) + CNT_WID'(w_xfer_2);
            if (r_state == S_ISSUE && (r_h1_valid || r_h2_valid) && !w_xfer_1 && !w_xfer_2)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign inst_1_fetch = (r_state == S_FETCH);
    assign inst_2_fetch = (r_state == S_FETCH);
    assign iss_1_type = r_h1_type; assign iss_1_dest = r_h1_dest;
    assign iss_1_src0 = r_h1_src0; assign iss_1_src1 = r_h1_src1;
    assign iss_2_type = r_h2_type; assign iss_2_dest = r_h2_dest;
    assign iss_2_src0 = r_h2_src0; assign iss_2_src1 = r_h2_src1;
    assign sb_busy    = r_sb_busy;
    assign issue_cnt  = r_issue_cnt;
    assign stall_cnt  = r_stall_cnt;

endmodule
